// File: rtl/regfile_pkg.sv
// Shared register-file package: clear-sequencer state encoding and default
// parameter values used by regfile_mp and its read-port sub-module.
package regfile_pkg;

   // Default geometry of the CPU register file.
   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_ADDR_W   = 5;
   localparam int unsigned DEF_N_RD     = 2;
   localparam int unsigned DEF_ZERO_REG = 1;

   // Clear sequencer: IDLE serves reads/writes, CLEAR zeroes one entry per cycle.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } seq_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One combinational read port of the register file: write-through bypass
// (wr1 over wr0), hard-wired zero entry, and forced-zero output while busy.
//   busy       : clear sequencer active, output forced to zero
//   rd_addr    : address being read
//   mem_data   : stored entry at rd_addr
//   wrN_act    : write N actually commits this cycle (already qualified)
//   wrN_addr   : write N address
//   wrN_data   : write N data
//   rd_data_c  : combinational read result
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
   input  logic              busy,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wr0_act,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   input  logic              wr1_act,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   output logic [DATA_W-1:0] rd_data_c
);

   logic zero_hit;

   assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);

   // Priority: busy / zero entry, then wr1 bypass, then wr0 bypass, then array.
   always_comb begin
      rd_data_c = '0;
      if (!busy && !zero_hit) begin
         if (wr1_act && (wr1_addr == rd_addr)) begin
            rd_data_c = wr1_data;
         end else if (wr0_act && (wr0_addr == rd_addr)) begin
            rd_data_c = wr0_data;
         end else begin
            rd_data_c = mem_data;
         end
      end
   end

endmodule : regfile_rdport

// File: rtl/regfile_mp.sv
// Multi-ported register file: N_RD combinational read ports with write-through
// bypass, two write ports (wr1 wins on collision), and a clear sequencer that
// zeroes the whole array one entry per cycle after reset or on clr_req.
//   clk, reset      : clock, synchronous active-high reset
//   rd_addr/rd_data : packed read ports, port k at [k*W +: W]
//   wrN_en/addr/data: write ports 0 and 1
//   clr_req         : request to zero the array (ignored while clearing)
//   busy            : clear sequencer running; writes dropped, reads return 0
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned N_RD     = DEF_N_RD,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr,
   output logic [N_RD*DATA_W-1:0]   rd_data,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     clr_req,
   output logic                     busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   seq_state_t        state, state_nxt;
   logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
   logic              wr0_act, wr1_act;

   logic [DATA_W-1:0] mem [DEPTH];

   // Sequencer state register; reset restarts the clear from entry 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   // Next-state logic: CLEAR walks 0..DEPTH-1 then returns to IDLE.
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         ST_IDLE: begin
            if (clr_req) begin
               state_nxt   = ST_CLEAR;
               clr_cnt_nxt = '0;
            end
         end
         ST_CLEAR: begin
            if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
               state_nxt   = ST_IDLE;
               clr_cnt_nxt = '0;
            end else begin
               clr_cnt_nxt = clr_cnt + ADDR_W'(1);
            end
         end
         default: begin
            state_nxt   = ST_CLEAR;
            clr_cnt_nxt = '0;
         end
      endcase
   end

   // busy is a direct decode of the state flop, so it has no input path.
   assign busy = (state == ST_CLEAR);

   // A write commits only in IDLE and never to the hard-wired zero entry.
   assign wr0_act = wr0_en && !busy && !((ZERO_REG != 0) && (wr0_addr == '0));
   assign wr1_act = wr1_en && !busy && !((ZERO_REG != 0) && (wr1_addr == '0));

   // Single array: clear port in CLEAR, otherwise wr0 then wr1 so wr1 wins.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
         end else begin
            if (wr0_act) begin
               mem[wr0_addr] <= wr0_data;
            end
            if (wr1_act) begin
               mem[wr1_addr] <= wr1_data;
            end
         end
      end
   end

   // One bypass/zero mux per read port.
   for (genvar k = 0; k < N_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr_k;
      logic [DATA_W-1:0] stored_k;

      assign addr_k   = rd_addr[k*ADDR_W +: ADDR_W];
      assign stored_k = mem[addr_k];

      regfile_rdport #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_rdport (
         .busy      (busy),
         .rd_addr   (addr_k),
         .mem_data  (stored_k),
         .wr0_act   (wr0_act),
         .wr0_addr  (wr0_addr),
         .wr0_data  (wr0_data),
         .wr1_act   (wr1_act),
         .wr1_addr  (wr1_addr),
         .wr1_data  (wr1_data),
         .rd_data_c (rd_data[k*DATA_W +: DATA_W])
      );
   end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed vector table, hand-written reset/clear
// sequences, and randomized traffic against a behavioural model.
module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int N_RD   = 2;
   localparam int DEPTH  = 32;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [N_RD*ADDR_W-1:0] rd_addr;
   logic [N_RD*DATA_W-1:0] rd_data;
   logic                   wr0_en, wr1_en, clr_req;
   logic [ADDR_W-1:0]      wr0_addr, wr1_addr;
   logic [DATA_W-1:0]      wr0_data, wr1_data;
   logic                   busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: contents plus number of clear cycles still to run.
   logic [DATA_W-1:0] m_mem [DEPTH];
   int                m_left = DEPTH;

   regfile_mp dut (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .clr_req  (clr_req),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              w0e;
      logic [ADDR_W-1:0] w0a;
      logic [DATA_W-1:0] w0d;
      logic              w1e;
      logic [ADDR_W-1:0] w1a;
      logic [DATA_W-1:0] w1d;
      logic              clr;
      logic [ADDR_W-1:0] ra0;
      logic [ADDR_W-1:0] ra1;
      logic [DATA_W-1:0] e0;
      logic [DATA_W-1:0] e1;
      logic              eb;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
      if (m_left > 0 || a == 0) return '0;
      if (wr1_en && wr1_addr == a) return wr1_data;
      if (wr0_en && wr0_addr == a) return wr0_data;
      return m_mem[a];
   endfunction

   // Array content during a clear is unobservable, so zero it all at the end.
   task automatic m_step();
      if (reset) begin
         m_left = DEPTH;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         end
      end else begin
         if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
         if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
         if (clr_req) m_left = DEPTH;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic idle_inputs();
      wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
      clr_req = 1'b0;
   endtask

   task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic check_model(input string tag);
      check({tag, "_rd0"}, rd_data[DATA_W-1:0], m_read(rd_addr[ADDR_W-1:0]));
      check({tag, "_rd1"}, rd_data[2*DATA_W-1:DATA_W], m_read(rd_addr[2*ADDR_W-1:ADDR_W]));
      check({tag, "_busy"}, DATA_W'(busy), DATA_W'(m_left > 0));
   endtask

   // Counts busy cycles until busy falls, bounded; returns the count.
   task automatic count_busy(input string tag, output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         check_model(tag);
         cnt++;
         tick();
         #2;
      end
   endtask

   initial begin
      int cnt;

      vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      vecs[2] = '{1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0, 5'd7, 5'd5, 32'h22222222, 32'hDEADBEEF, 1'b0};
      vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7, 32'h22222222, 32'h22222222, 1'b0};
      vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0};
      vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0};
      vecs[6] = '{1'b1, 5'd3, 32'h5, 1'b1, 5'd0, 32'h123, 1'b0, 5'd0, 5'd3, 32'h0, 32'h5, 1'b0};
      vecs[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd7, 32'h5, 32'h22222222, 1'b0};
      vecs[8] = '{1'b1, 5'd9, 32'hABCD, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 32'hABCD, 32'hABCD, 1'b0};
      vecs[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd3, 32'h0, 32'h0, 1'b1};

      reset = 1'b1;
      idle_inputs();
      set_rd(5'd0, 5'd0);

      // Reset held 3 cycles, then a 32-cycle clear.
      repeat (3) tick();
      #2;
      check("reset_busy", DATA_W'(busy), 32'd1);
      reset = 1'b0;
      #1;
      count_busy("rst_clr", cnt);
      check("rst_clr_len", DATA_W'(cnt), 32'd32);
      for (int a = 0; a < DEPTH; a += 2) begin
         set_rd(ADDR_W'(a), ADDR_W'(a + 1));
         #2;
         check("post_clr_rd0", rd_data[DATA_W-1:0], 32'h0);
         check("post_clr_rd1", rd_data[2*DATA_W-1:DATA_W], 32'h0);
         tick();
      end

      // Directed vectors.
      for (int i = 0; i < 10; i++) begin
         wr0_en = vecs[i].w0e; wr0_addr = vecs[i].w0a; wr0_data = vecs[i].w0d;
         wr1_en = vecs[i].w1e; wr1_addr = vecs[i].w1a; wr1_data = vecs[i].w1d;
         clr_req = vecs[i].clr;
         set_rd(vecs[i].ra0, vecs[i].ra1);
         #2;
         check($sformatf("vec%0d_rd0", i), rd_data[DATA_W-1:0], vecs[i].e0);
         check($sformatf("vec%0d_rd1", i), rd_data[2*DATA_W-1:DATA_W], vecs[i].e1);
         check($sformatf("vec%0d_busy", i), DATA_W'(busy), DATA_W'(vecs[i].eb));
         check_model($sformatf("vec%0d_mdl", i));
         tick();
      end

      // Writes during the clear started above are dropped.
      idle_inputs();
      wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hABCD;
      wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hABCD;
      set_rd(5'd9, 5'd5);
      #1;
      count_busy("wr_busy", cnt);
      check("wr_busy_len", DATA_W'(cnt), 32'd31);
      idle_inputs();
      #1;
      check("r9_after_clr", rd_data[DATA_W-1:0], 32'h0);
      check("r5_after_clr", rd_data[2*DATA_W-1:DATA_W], 32'h0);
      tick();

      // Reset in the middle of a clr_req-triggered clear restarts it.
      wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h5;
      tick();
      idle_inputs();
      set_rd(5'd3, 5'd3);
      #2;
      check("r3_written", rd_data[DATA_W-1:0], 32'h5);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (10) tick();
      #2;
      check("midclr_busy", DATA_W'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      count_busy("rst_mid", cnt);
      check("rst_mid_len", DATA_W'(cnt), 32'd32);
      check("r3_cleared", rd_data[DATA_W-1:0], 32'h0);
      tick();

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         reset    = ($urandom_range(0, 149) == 0);
         clr_req  = ($urandom_range(0, 79) == 0);
         wr0_en   = $urandom_range(0, 1) == 1;
         wr1_en   = $urandom_range(0, 1) == 1;
         wr0_addr = ADDR_W'($urandom_range(0, 7));
         wr1_addr = ADDR_W'($urandom_range(0, 7));
         wr0_data = $urandom;
         wr1_data = $urandom;
         if ($urandom_range(0, 3) == 0) set_rd(ADDR_W'($urandom), ADDR_W'($urandom));
         else set_rd(ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
         #2;
         check_model("rand");
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter N_RD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 entry 0 is hard-wired to zero.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rd_addr  input  N_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  output  N_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-009 wr0_en, wr1_en  input  1 each  write enables, ports 0 and 1.
REQ-010 wr0_addr, wr1_addr  input  ADDR_W each  write addresses.
REQ-011 wr0_data, wr1_data  input  DATA_W each  write data.
REQ-012 clr_req  input  1  one-cycle request to zero the whole array.
REQ-013 busy  output  1  high while the clear sequencer runs; writes ignored, reads return zero.

Function
REQ-014 The block SHALL have a two-state sequencer: IDLE and CLEAR.
REQ-015 In CLEAR, one entry per cycle SHALL be written to zero, at index clr_cnt, with clr_cnt going 0..DEPTH-1.
REQ-016 After the cycle that clears DEPTH-1, the sequencer SHALL go to IDLE with clr_cnt = 0, so CLEAR lasts exactly DEPTH cycles.
REQ-017 busy SHALL equal (state == CLEAR), registered, with no combinational path from inputs.
REQ-018 In IDLE, clr_req = 1 SHALL move the sequencer to CLEAR on the next edge; clr_req in CLEAR SHALL be ignored.
REQ-019 In IDLE, wrN_en = 1 SHALL write wrN_data to entry wrN_addr at the rising edge.
REQ-020 If both ports write the same address in one cycle, wr1 SHALL win.
REQ-021 When ZERO_REG = 1, writes to address 0 SHALL be dropped, and reads of address 0 SHALL return 0 on every port, bypass included.
REQ-022 Reads SHALL be combinational and independent per port.
REQ-023 A read SHALL return the value being written in the same cycle when an enabled write targets the same address (write-through bypass), using the REQ-020 priority.
REQ-024 With no matching write, a read SHALL return the stored entry.
REQ-025 While busy = 1, all rd_data SHALL be 0, and wr0_en/wr1_en SHALL have no effect.
REQ-026 A write and clr_req in the same IDLE cycle: the write SHALL commit, then CLEAR SHALL begin and later zero that entry.

Reset
REQ-027 reset = 1 at a rising edge SHALL force state = CLEAR and clr_cnt = 0, so busy = 1 from the next cycle.
REQ-028 Reset held N cycles SHALL hold clr_cnt at 0; the DEPTH-cycle clear SHALL start on the first edge with reset = 0.
REQ-029 Reset during an active CLEAR SHALL restart the clear from index 0.
REQ-030 No file load or other initial-content mechanism SHALL exist; the array contents after a clear are defined as all zeros.
REQ-031 Reset SHALL take priority over clr_req and over writes.

Structure
REQ-032 The state encoding (IDLE/CLEAR) and the default parameter values SHALL live in the shared CPU package (regfile_pkg).
REQ-033 The bypass/zero-mux for one read port SHALL be a sub-module, regfile_rdport, instantiated N_RD times by generate loop.
REQ-034 The array SHALL be a single memory with two write ports plus the clear port, with no per-port copies.

Verification
REQ-035 Reset 3 cycles, then release -> busy = 1 for exactly 32 cycles (default params), then 0; every address reads 0.
REQ-036 IDLE: write 0xDEADBEEF to r5 via wr0, then read r5 on both ports next cycle -> 0xDEADBEEF on both; a same-cycle read returns it via bypass.
REQ-037 wr0 (r7, 0x11111111) and wr1 (r7, 0x22222222) in the same cycle -> r7 = 0x22222222, and the bypass read also shows 0x22222222.
REQ-038 Write 0xFFFFFFFF to r0 with ZERO_REG = 1 -> r0 reads 0 in the same and the next cycle.
REQ-039 clr_req with r3 = 0x5; assert reset at clear cycle 10 -> busy stays 1, and CLEAR completes 32 cycles after reset release; r3 reads 0.
REQ-040 Write during busy (r9, 0xABCD) -> no effect; after busy falls, r9 reads 0.
